// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load port and back-to-back framing.
// Optional PISO_PARITY_EN appends one even-parity bit after the data bits of each frame.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic parity;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] loaded_shift;
    logic [WIDTH-1:0] shifted;

    // so_last marks the final bit cycle, which is exactly when a chained word may be taken
    always_comb begin
        load_ready   = (state == IDLE) || so_last;
        accept       = load_valid && load_ready;
        first_bit    = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
        next_bit     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        loaded_shift = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
        shifted      = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    assign busy = so_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity   <= 1'b0;
`endif
        end else if (accept) begin
            // First bit leaves on the accepting edge; cnt holds the bits still to come
            state    <= SHIFT;
            shreg    <= loaded_shift;
            cnt      <= CW'(WIDTH - 1);
            so       <= first_bit;
            so_valid <= 1'b1;
            so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity   <= ^load_data;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        so    <= next_bit;
                        shreg <= shifted;
                        cnt   <= cnt - CW'(1);
`ifdef PISO_PARITY_EN
                        so_last <= 1'b0;
`else
                        so_last <= (cnt == CW'(1));
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state   <= PARITY;
                        so      <= parity;
                        so_last <= 1'b1;
`else
                        state    <= IDLE;
                        so       <= 1'b0;
                        so_valid <= 1'b0;
                        so_last  <= 1'b0;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state    <= IDLE;
                    so       <= 1'b0;
                    so_valid <= 1'b0;
                    so_last  <= 1'b0;
                end
`endif
                default: begin
                    state    <= IDLE;
                    so       <= 1'b0;
                    so_valid <= 1'b0;
                    so_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven bench: an MSB-first and an LSB-first instance share one load port.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       ready_m, so_m, sov_m, last_m, busy_m;
    logic       ready_l, so_l, sov_l, last_l, busy_l;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_m),
        .load_data(load_data), .so(so_m), .so_valid(sov_m), .so_last(last_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_l),
        .load_data(load_data), .so(so_l), .so_valid(sov_l), .so_last(last_l), .busy(busy_l)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_m;   // send order, first bit at [7]
        logic [7:0] seq_l;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " so_m"}, so_m, 0);
        chk({tag, " so_l"}, so_l, 0);
        chk({tag, " sov_m"}, sov_m, 0);
        chk({tag, " sov_l"}, sov_l, 0);
        chk({tag, " last_m"}, last_m, 0);
        chk({tag, " busy_m"}, busy_m, 0);
        chk({tag, " ready_m"}, ready_m, 1);
        chk({tag, " ready_l"}, ready_l, 1);
    endtask

    // Check bit i of a frame; called at the negedge inside that bit cycle.
    task automatic chk_bit(input int i, input vec_t v);
        logic em, el;
        bit   last;
        last = (i == FRAME - 1);
        if (i < 8) begin
            em = v.seq_m[7 - i];
            el = v.seq_l[7 - i];
        end else begin
            em = v.par;
            el = v.par;
        end
        chk($sformatf("d%02h b%0d so_m", v.data, i), so_m, em);
        chk($sformatf("d%02h b%0d so_l", v.data, i), so_l, el);
        chk($sformatf("d%02h b%0d sov", v.data, i), {sov_m, sov_l, busy_m, busy_l}, 4'hF);
        chk($sformatf("d%02h b%0d last", v.data, i), {last_m, last_l}, last ? 2'b11 : 2'b00);
        chk($sformatf("d%02h b%0d ready", v.data, i), {ready_m, ready_l}, last ? 2'b11 : 2'b00);
    endtask

    // Send one word; optionally pulse load_valid with junk while busy (must be ignored).
    task automatic send(input vec_t v, input bit poke);
        @(negedge clk);
        chk("pre ready", {ready_m, ready_l}, 2'b11);
        load_valid = 1'b1;
        load_data  = v.data;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            chk_bit(i, v);
            if (poke && i >= 1 && i <= 3) begin
                load_valid = 1'b1;
                load_data  = 8'h00;
            end else begin
                load_valid = 1'b0;
                load_data  = v.data;
            end
            @(negedge clk);
        end
        chk_idle("post");
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
        vecs[2] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0};
        vecs[3] = '{8'h0F, 8'b00001111, 8'b11110000, 1'b0};
        vecs[4] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
        vecs[5] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
        vecs[6] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
        vecs[7] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 chk_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) send(vecs[k], 1'b0);

        // Loads offered mid-frame must not disturb the frame in flight
        send(vecs[0], 1'b1);

        // Back-to-back F0 then 0F with load_valid held
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hF0;
        @(negedge clk);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i < FRAME) chk_bit(i, vecs[2]);
            else chk_bit(i - FRAME, vecs[3]);
            if (i == FRAME - 1) load_data = 8'h0F;
            else if (i >= FRAME) load_valid = 1'b0;
            @(negedge clk);
        end
        chk_idle("chain end");

        // Reset after three bits of 8'hFF
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ff b%0d so", i), {so_m, so_l, sov_m}, 3'b111);
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1 chk_idle("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle($sformatf("after rst %0d", i));
        end
        send(vecs[6], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
